mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_lfsr.sv | 37 +++
 rtl/mem_responder.sv | 174 +++++++++++++++++
 tb/tb_mem_responder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder slice.
package mem_pkg;

    // Responder control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Wait counter width: must hold WAIT_STATES (max 15) plus a random
    // extra of up to 3 cycles.
    localparam int WAIT_CNT_W = 5;

    // A strobe of all zeros marks a read.
    localparam logic [3:0] WSTRB_READ = 4'b0000;

    // Fibonacci LFSR taps 8,6,5,4 (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/mem_responder_if.sv
// valid/ready memory bus between an initiator (master) and a responder (slave).
interface mem_responder_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances once per step pulse.
// Only instantiated when MEM_RESPONDER_RAND_WAIT_EN is defined.
module mem_lfsr
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] value
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       fb;

    // Next LFSR value: shift in the tap parity when stepping.
    always_comb begin
        fb     = ^(lfsr_q & LFSR_TAPS);
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = {lfsr_q[6:0], fb};
        end
    end

    // LFSR register, reloaded with the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/mem_responder.sv
// Word-RAM bus responder with programmable wait states, byte write
// strobes and a sticky out-of-range flag.
// Optional macro MEM_RESPONDER_RAND_WAIT_EN adds 0..3 pseudo-random extra
// wait cycles per transaction (timing only; data behaviour unchanged).
module mem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    output logic            oob
);

    localparam int IDX_W = $clog2(DEPTH);
    typedef logic [WAIT_CNT_W-1:0] cnt_t;

    state_t             state_q, state_d;
    cnt_t               cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               oob_q, oob_d;

    // Request fields captured when a request is accepted in IDLE.
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic               inrange_q;

    logic [31:0]        ram [DEPTH];

    logic [31:0]        offset;
    logic [31:0]        index32;
    logic               live_inrange;
    logic               latch_en;
    logic               enter_resp;
    cnt_t               wait_total;

    logic [IDX_W-1:0]   req_idx;
    logic [31:0]        req_wdata;
    logic [3:0]         req_wstrb;
    logic               req_inrange;
    logic               ram_we;

    // Range check in wrapping 32-bit arithmetic: addresses below the base
    // become huge indices and fall out of range.
    assign offset       = bus.mem_addr - BASE_ADDR;
    assign index32      = offset >> 2;
    assign live_inrange = (index32 < 32'(DEPTH));

`ifdef MEM_RESPONDER_RAND_WAIT_EN
    logic [7:0] lfsr_val;

    mem_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (latch_en),
        .seed  (LFSR_SEED),
        .value (lfsr_val)
    );

    assign wait_total = cnt_t'(WAIT_STATES) + cnt_t'(lfsr_val[1:0]);
`else
    assign wait_total = cnt_t'(WAIT_STATES);
`endif

    // With zero wait the commit happens on the accept edge itself, so the
    // request is taken straight from the bus; otherwise from the latches.
    assign req_idx     = (state_q == IDLE) ? index32[IDX_W-1:0] : idx_q;
    assign req_wdata   = (state_q == IDLE) ? bus.mem_wdata      : wdata_q;
    assign req_wstrb   = (state_q == IDLE) ? bus.mem_wstrb      : wstrb_q;
    assign req_inrange = (state_q == IDLE) ? live_inrange       : inrange_q;

    // Next-state, completion and response data.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = 1'b0;
        rdata_d    = rdata_q;
        oob_d      = oob_q;
        latch_en   = 1'b0;
        enter_resp = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    latch_en = 1'b1;
                    if (wait_total == '0) begin
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = wait_total - cnt_t'(1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp) begin
            state_d = RESP;
            ready_d = 1'b1;
            if (!req_inrange) begin
                oob_d   = 1'b1;
                rdata_d = 32'h0;
            end else if (req_wstrb == WSTRB_READ) begin
                rdata_d = ram[req_idx];
            end else begin
                rdata_d = 32'h0;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            oob_q   <= oob_d;
        end
    end

    // Request capture on acceptance; data path, so no reset.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            idx_q     <= index32[IDX_W-1:0];
            wdata_q   <= bus.mem_wdata;
            wstrb_q   <= bus.mem_wstrb;
            inrange_q <= live_inrange;
        end
    end

    // A reset on the commit edge discards the pending write.
    assign ram_we = enter_resp && req_inrange && (req_wstrb != WSTRB_READ) && !rst;

    // Byte-strobed RAM write; unstrobed bytes keep their old contents.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wstrb[i]) begin
                    ram[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign oob           = oob_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with different wait
// states / address windows share one driver, selected by drv_sel.
module tb_mem_responder;

`ifdef MEM_RESPONDER_RAND_WAIT_EN
    localparam int RND = 3;
`else
    localparam int RND = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;

    int          drv_sel   = 0;
    logic        drv_valid = 1'b0;
    logic [31:0] drv_addr  = 32'h0;
    logic [31:0] drv_wdata = 32'h0;
    logic [3:0]  drv_wstrb = 4'h0;

    logic        oob_a, oob_b, oob_c;
    logic        ready_m;
    logic [31:0] rdata_m;
    logic        oob_m;

    int          n_asrt = 0;
    int          n_fail = 0;

    mem_responder_if ifa ();
    mem_responder_if ifb ();
    mem_responder_if ifc ();

    assign ifa.mem_valid = drv_valid && (drv_sel == 0);
    assign ifb.mem_valid = drv_valid && (drv_sel == 1);
    assign ifc.mem_valid = drv_valid && (drv_sel == 2);
    assign ifa.mem_addr  = drv_addr;
    assign ifb.mem_addr  = drv_addr;
    assign ifc.mem_addr  = drv_addr;
    assign ifa.mem_wdata = drv_wdata;
    assign ifb.mem_wdata = drv_wdata;
    assign ifc.mem_wdata = drv_wdata;
    assign ifa.mem_wstrb = drv_wstrb;
    assign ifb.mem_wstrb = drv_wstrb;
    assign ifc.mem_wstrb = drv_wstrb;

    mem_responder #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_STATES(0), .LFSR_SEED(8'hA5))
        dut_a (.clk(clk), .rst(rst), .bus(ifa), .oob(oob_a));
    mem_responder #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_STATES(3), .LFSR_SEED(8'h5C))
        dut_b (.clk(clk), .rst(rst), .bus(ifb), .oob(oob_b));
    mem_responder #(.BASE_ADDR(32'h1000), .DEPTH(16), .WAIT_STATES(4), .LFSR_SEED(8'h33))
        dut_c (.clk(clk), .rst(rst), .bus(ifc), .oob(oob_c));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        ready_m = 1'b0;
        rdata_m = 32'h0;
        oob_m   = 1'b0;
        case (drv_sel)
            0: begin ready_m = ifa.mem_ready; rdata_m = ifa.mem_rdata; oob_m = oob_a; end
            1: begin ready_m = ifb.mem_ready; rdata_m = ifb.mem_rdata; oob_m = oob_b; end
            default: begin ready_m = ifc.mem_ready; rdata_m = ifc.mem_rdata; oob_m = oob_c; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_asrt++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Waits (bounded) for a ready pulse; n is the edge count, 0 on timeout.
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready_m) begin
                n = i;
                break;
            end
        end
    endtask

    // One complete transaction. lat counts cycles with the valid cycle as
    // cycle 1, so a zero-wait responder answers with lat = 2. Returns with
    // the responder back in IDLE.
    task automatic xact(input int sel, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, output logic [31:0] rd, output int lat);
        int n;
        drv_sel   = sel;
        drv_addr  = addr;
        drv_wdata = wd;
        drv_wstrb = strb;
        drv_valid = 1'b1;
        wait_ready(n);
        rd  = rdata_m;
        lat = (n == 0) ? -1 : n + 1;
        drv_valid = 1'b0;
        @(posedge clk); #1;
        chk("ready_one_cycle", 32'(ready_m), 32'h0);
    endtask

    logic [31:0] rd;
    int          lat;
    int          n1, r1, r2;
    logic [31:0] model [16];

    initial begin
        // Reset state of every instance.
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            drv_sel = s;
            #0;
            chk("rst_ready", 32'(ready_m), 32'h0);
            chk("rst_rdata", rdata_m, 32'h0);
            chk("rst_oob", 32'(oob_m), 32'h0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero wait states: full write then read.
        xact(0, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
        chk_rng("a_wr_lat", lat, 2, 2 + RND);
        chk("a_wr_rdata", rd, 32'h0);
        xact(0, 32'h10, 32'h0, 4'h0, rd, lat);
        chk_rng("a_rd_lat", lat, 2, 2 + RND);
        chk("a_rd_data", rd, 32'hDEADBEEF);
        chk("a_rdata_hold", rdata_m, 32'hDEADBEEF);

        // Byte strobes: lanes 0 and 2 replaced.
        xact(0, 32'h20, 32'h11223344, 4'hF, rd, lat);
        xact(0, 32'h20, 32'hAABBCCDD, 4'b0101, rd, lat);
        xact(0, 32'h20, 32'h0, 4'h0, rd, lat);
        chk("a_strobe_merge", rd, 32'h11BB33DD);

        // Top word in range; index 1024 out of range.
        xact(0, 32'h0, 32'h0BADF00D, 4'hF, rd, lat);
        xact(0, 32'hFFC, 32'h5A5A5A5A, 4'hF, rd, lat);
        xact(0, 32'hFFC, 32'h0, 4'h0, rd, lat);
        chk("a_last_word", rd, 32'h5A5A5A5A);
        chk("a_oob_clear", 32'(oob_m), 32'h0);
        xact(0, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, lat);
        chk_rng("a_oob_wr_lat", lat, 2, 2 + RND);
        chk("a_oob_set", 32'(oob_m), 32'h1);
        xact(0, 32'h0, 32'h0, 4'h0, rd, lat);
        chk("a_word0_kept", rd, 32'h0BADF00D);
        xact(0, 32'h1000, 32'h0, 4'h0, rd, lat);
        chk("a_oob_rd_zero", rd, 32'h0);
        chk("a_oob_sticky", 32'(oob_m), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("a_oob_after_rst", 32'(oob_m), 32'h0);
        chk("a_rdata_after_rst", rdata_m, 32'h0);

        // Three wait states: latency, single-cycle pulse, back-to-back spacing.
        xact(1, 32'h40, 32'h01234567, 4'hF, rd, lat);
        chk_rng("b_wr_lat", lat, 5, 5 + RND);
        xact(1, 32'h44, 32'h89ABCDEF, 4'hF, rd, lat);
        drv_sel   = 1;
        drv_addr  = 32'h40;
        drv_wstrb = 4'h0;
        drv_valid = 1'b1;
        wait_ready(n1);
        r1 = cyc;
        chk_rng("b_b2b_lat", n1 + 1, 5, 5 + RND);
        chk("b_b2b_rd0", rdata_m, 32'h01234567);
        drv_addr = 32'h44;
        @(posedge clk); #1;
        chk("b_b2b_pulse_low", 32'(ready_m), 32'h0);
        wait_ready(n1);
        r2 = cyc;
        drv_valid = 1'b0;
        chk("b_b2b_rd1", rdata_m, 32'h89ABCDEF);
        chk_rng("b_b2b_spacing", r2 - r1, 5, 5 + RND);
        @(posedge clk); #1;

        // Offset window (base 0x1000, 16 words) and both wrap directions.
        xact(2, 32'h1000, 32'h01010101, 4'hF, rd, lat);
        chk_rng("c_wr_lat", lat, 6, 6 + RND);
        xact(2, 32'h103C, 32'h3C3C3C3C, 4'hF, rd, lat);
        xact(2, 32'h103C, 32'h0, 4'h0, rd, lat);
        chk("c_last_word", rd, 32'h3C3C3C3C);
        chk("c_oob_clear", 32'(oob_m), 32'h0);
        xact(2, 32'h1040, 32'hEEEEEEEE, 4'hF, rd, lat);
        chk("c_oob_above", 32'(oob_m), 32'h1);
        xact(2, 32'h1000, 32'h0, 4'h0, rd, lat);
        chk("c_word0_kept", rd, 32'h01010101);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        xact(2, 32'h0FFC, 32'h0, 4'h0, rd, lat);
        chk("c_below_rd_zero", rd, 32'h0);
        chk("c_oob_below", 32'(oob_m), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset during WAIT aborts the write with no ready pulse.
        xact(2, 32'h1008, 32'h12345678, 4'hF, rd, lat);
        drv_addr  = 32'h1008;
        drv_wdata = 32'hCAFEF00D;
        drv_wstrb = 4'hF;
        drv_valid = 1'b1;
        @(posedge clk); #1;
        chk("c_abort_rdy0", 32'(ready_m), 32'h0);
        @(posedge clk); #1;
        chk("c_abort_rdy1", 32'(ready_m), 32'h0);
        rst       = 1'b1;
        drv_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("c_abort_rdy2", 32'(ready_m), 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("c_abort_quiet", 32'(ready_m), 32'h0);
        end
        xact(2, 32'h1008, 32'h0, 4'h0, rd, lat);
        chk_rng("c_after_abort_lat", lat, 6, 6 + RND);
        chk("c_abort_word_kept", rd, 32'h12345678);

        // Random reads/writes against a reference model on instance B.
        for (int i = 0; i < 16; i++) begin
            model[i] = 32'hA0A0A0A0 ^ (32'(i) * 32'h01010101);
            xact(1, 32'h200 + 32'(i) * 4, model[i], 4'hF, rd, lat);
        end
        for (int k = 0; k < 100; k++) begin
            int          idx;
            logic [3:0]  strb;
            logic [31:0] wd;
            idx  = $urandom_range(0, 15);
            strb = 4'($urandom_range(0, 15));
            wd   = $urandom;
            xact(1, 32'h200 + 32'(idx) * 4, wd, strb, rd, lat);
            chk_rng("rnd_lat", lat, 5, 5 + RND);
            if (strb == 4'h0) begin
                chk("rnd_rd", rd, model[idx]);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
                end
                chk("rnd_wr_rdata", rd, 32'h0);
            end
        end
        for (int i = 0; i < 16; i++) begin
            xact(1, 32'h200 + 32'(i) * 4, 32'h0, 4'h0, rd, lat);
            chk("rnd_final", rd, model[i]);
        end
        chk("rnd_no_oob", 32'(oob_m), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
